// File: rtl/clock_pkg.sv
// Shared types and constants for the digital-clock user-input front end.
package clock_pkg;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    RUN       = 2'd1,
    SET_TIME  = 2'd2,
    SET_ALARM = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    HOUR = 2'd0,
    MIN  = 2'd1,
    SEC  = 2'd2
  } field_e;

  localparam logic [1:0] MODE_RUN       = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;

  // Fields are held as packed BCD {shi, ge}.
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  localparam logic [7:0] RST_HOUR    = 8'h12;
  localparam logic [7:0] RST_MIN     = 8'h59;
  localparam logic [7:0] RST_SEC     = 8'h45;
  localparam logic [7:0] RST_AL_HOUR = 8'h07;
  localparam logic [7:0] RST_AL_MIN  = 8'h00;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> synchronised, debounced level -> one-cycle press pulse.
module key_debounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Counter only runs while the synced input disagrees with the accepted level.
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Clock user-input front end: mode FSM, field cursor and BCD preset/alarm editors.
//   state     | meaning
//   LOAD      | one cycle after reset, downstream loads the preset
//   RUN       | clock running; inc toggles the alarm enable
//   SET_TIME  | editing preset hour/min/sec
//   SET_ALARM | editing alarm hour/min
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_sel_n,
  input  logic       key_inc_n,
  output logic       set_time_finish,
  output logic [3:0] set_sec_ge,
  output logic [3:0] set_sec_shi,
  output logic [3:0] set_min_ge,
  output logic [3:0] set_min_shi,
  output logic [3:0] set_hour_ge,
  output logic [3:0] set_hour_shi,
  output logic       clock_en,
  output logic [3:0] clock_min_ge,
  output logic [3:0] clock_min_shi,
  output logic [3:0] clock_hour_ge,
  output logic [3:0] clock_hour_shi,
  output logic [1:0] mode,
  output logic [1:0] cur_field
);

  logic mode_p, sel_p, inc_p;

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .key_n(key_mode_n), .press(mode_p));
  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_sel (
    .clk(clk), .rst_n(rst_n), .key_n(key_sel_n), .press(sel_p));
  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .key_n(key_inc_n), .press(inc_p));

  state_e     state_q, state_d;
  field_e     field_q, field_d;
  logic       fin_q, fin_d;
  logic [1:0] mode_q, mode_d;
  logic       en_q, en_d;
  logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [7:0] al_hour_q, al_hour_d, al_min_q, al_min_d;

  always_comb begin
    state_d   = state_q;
    field_d   = field_q;
    en_d      = en_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    // Priority mode > sel > inc; losers in the same cycle are dropped.
    case (state_q)
      LOAD: state_d = RUN;
      RUN: begin
        if (mode_p) begin
          state_d = SET_TIME;
          field_d = HOUR;
        end else if (!sel_p && inc_p) begin
          en_d = ~en_q;
        end
      end
      SET_TIME: begin
        if (mode_p) begin
          state_d = SET_ALARM;
          field_d = HOUR;
        end else if (sel_p) begin
          field_d = (field_q == HOUR) ? MIN : (field_q == MIN) ? SEC : HOUR;
        end else if (inc_p) begin
          case (field_q)
            HOUR:    hour_d = bcd_inc(hour_q, HOUR_MAX);
            MIN:     min_d  = bcd_inc(min_q, MIN_MAX);
            default: sec_d  = bcd_inc(sec_q, SEC_MAX);
          endcase
        end
      end
      SET_ALARM: begin
        if (mode_p) begin
          state_d = RUN;
          field_d = HOUR;
        end else if (sel_p) begin
          field_d = (field_q == HOUR) ? MIN : HOUR;
        end else if (inc_p) begin
          if (field_q == MIN) al_min_d  = bcd_inc(al_min_q, MIN_MAX);
          else                al_hour_d = bcd_inc(al_hour_q, HOUR_MAX);
        end
      end
      default: state_d = LOAD;
    endcase
    fin_d = (state_d == RUN) || (state_d == SET_ALARM);
    case (state_d)
      SET_TIME:  mode_d = MODE_SET_TIME;
      SET_ALARM: mode_d = MODE_SET_ALARM;
      default:   mode_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      field_q   <= HOUR;
      fin_q     <= 1'b0;
      mode_q    <= MODE_RUN;
      en_q      <= 1'b0;
      hour_q    <= RST_HOUR;
      min_q     <= RST_MIN;
      sec_q     <= RST_SEC;
      al_hour_q <= RST_AL_HOUR;
      al_min_q  <= RST_AL_MIN;
    end else begin
      state_q   <= state_d;
      field_q   <= field_d;
      fin_q     <= fin_d;
      mode_q    <= mode_d;
      en_q      <= en_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
    end
  end

  assign set_time_finish = fin_q;
  assign mode            = mode_q;
  assign cur_field       = field_q;
  assign clock_en        = en_q;
  assign {set_hour_shi, set_hour_ge}     = hour_q;
  assign {set_min_shi, set_min_ge}       = min_q;
  assign {set_sec_shi, set_sec_ge}       = sec_q;
  assign {clock_hour_shi, clock_hour_ge} = al_hour_q;
  assign {clock_min_shi, clock_min_ge}   = al_min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed walk of the user flow plus random key noise, all against a time/history model.
module tb_time_set_ctrl;
  localparam int DB = 4;
  localparam int M_LOAD = 0, M_RUN = 1, M_ST = 2, M_SA = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_mode_n = 1'b1, key_sel_n = 1'b1, key_inc_n = 1'b1;
  logic       set_time_finish, clock_en;
  logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
  logic [3:0] clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi;
  logic [1:0] mode, cur_field;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.DB_CYCLES(DB), .DB_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_mode_n(key_mode_n), .key_sel_n(key_sel_n), .key_inc_n(key_inc_n),
    .set_time_finish(set_time_finish),
    .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi),
    .set_min_ge(set_min_ge), .set_min_shi(set_min_shi),
    .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
    .clock_en(clock_en),
    .clock_min_ge(clock_min_ge), .clock_min_shi(clock_min_shi),
    .clock_hour_ge(clock_hour_ge), .clock_hour_shi(clock_hour_shi),
    .mode(mode), .cur_field(cur_field));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer time fields, per-key raw-sample history.
  int  mst, mfld, mh, mm, ms, mah, mam, men;
  bit  mlvl[3];
  bit  mp[3];
  bit  hist[3][DB+2];

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model_reset();
    mst = M_LOAD; mfld = 0; mh = 12; mm = 59; ms = 45; mah = 7; mam = 0; men = 0;
    for (int k = 0; k < 3; k++) begin
      mlvl[k] = 1'b1;
      mp[k] = 1'b0;
      for (int i = 0; i < DB + 2; i++) hist[k][i] = 1'b1;
    end
  endtask

  task automatic model_step();
    bit r[3];
    bit stable, nl;
    r[0] = key_mode_n; r[1] = key_sel_n; r[2] = key_inc_n;
    if (mst == M_LOAD) mst = M_RUN;
    else if (mp[0]) begin
      mst  = (mst == M_RUN) ? M_ST : (mst == M_ST) ? M_SA : M_RUN;
      mfld = 0;
    end else if (mp[1]) begin
      if (mst == M_ST) mfld = (mfld + 1) % 3;
      else if (mst == M_SA) mfld = 1 - mfld;
    end else if (mp[2]) begin
      case (mst)
        M_RUN: men = 1 - men;
        M_ST: begin
          if (mfld == 0) mh = (mh + 1) % 24;
          else if (mfld == 1) mm = (mm + 1) % 60;
          else ms = (ms + 1) % 60;
        end
        M_SA: begin
          if (mfld == 0) mah = (mah + 1) % 24;
          else mam = (mam + 1) % 60;
        end
        default: ;
      endcase
    end
    // Level flips once the raw value two samples back has held the other value for DB samples.
    for (int k = 0; k < 3; k++) begin
      for (int i = DB + 1; i > 0; i--) hist[k][i] = hist[k][i-1];
      hist[k][0] = r[k];
      stable = 1'b1;
      for (int i = 2; i <= DB + 1; i++) if (hist[k][i] == mlvl[k]) stable = 1'b0;
      nl = stable ? ~mlvl[k] : mlvl[k];
      mp[k] = mlvl[k] & ~nl;
      mlvl[k] = nl;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("set_time_finish", 32'(set_time_finish), 32'(mst == M_RUN || mst == M_SA));
    chk("mode", 32'(mode), (mst == M_ST) ? 1 : (mst == M_SA) ? 2 : 0);
    chk("cur_field", 32'(cur_field), mfld);
    chk("clock_en", 32'(clock_en), men);
    chk("preset_hour", 32'({set_hour_shi, set_hour_ge}), 32'(bcd(mh)));
    chk("preset_min", 32'({set_min_shi, set_min_ge}), 32'(bcd(mm)));
    chk("preset_sec", 32'({set_sec_shi, set_sec_ge}), 32'(bcd(ms)));
    chk("alarm_hour", 32'({clock_hour_shi, clock_hour_ge}), 32'(bcd(mah)));
    chk("alarm_min", 32'({clock_min_shi, clock_min_ge}), 32'(bcd(mam)));
    if (rst_n) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [2:0] low_mask);
    key_mode_n = ~low_mask[0];
    key_sel_n  = ~low_mask[1];
    key_inc_n  = ~low_mask[2];
  endtask

  task automatic press(input logic [2:0] low_mask, input int hold);
    set_keys(low_mask);
    repeat (hold) tick();
    set_keys(3'b000);
    repeat (8) tick();
  endtask

  task automatic check_reset_literals(input string tag);
    chk({tag, "_fin"}, 32'(set_time_finish), 0);
    chk({tag, "_mode"}, 32'(mode), 0);
    chk({tag, "_field"}, 32'(cur_field), 0);
    chk({tag, "_time"}, 32'({set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge}), 32'h125945);
    chk({tag, "_alarm"}, 32'({clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge}), 32'h0700);
    chk({tag, "_en"}, 32'(clock_en), 0);
  endtask

  localparam logic [2:0] K_MODE = 3'b001, K_SEL = 3'b010, K_INC = 3'b100;

  initial begin
    int rem[3];
    bit lv[3];
    repeat (3) tick();
    check_reset_literals("reset");
    rst_n = 1'b1;
    chk("load_fin_low", 32'(set_time_finish), 0);
    tick();
    chk("run_fin_high", 32'(set_time_finish), 1);
    chk("run_time", 32'({set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge}), 32'h125945);

    // Short bounces on inc must not toggle the alarm enable.
    for (int g = 0; g < 3; g++) begin
      set_keys(K_INC); repeat (2) tick();
      set_keys(3'b000); repeat (3) tick();
    end
    repeat (6) tick();
    chk("glitch_no_toggle", 32'(clock_en), 0);
    set_keys(K_INC);
    repeat (DB + 2) tick();
    chk("latency_before", 32'(clock_en), 0);
    tick();
    chk("latency_at", 32'(clock_en), 1);
    repeat (10 - (DB + 3)) tick();
    set_keys(3'b000);
    repeat (8) tick();
    chk("held_single_toggle", 32'(clock_en), 1);

    press(K_MODE, 8);
    chk("st_fin", 32'(set_time_finish), 0);
    chk("st_mode", 32'(mode), 1);
    repeat (11) press(K_INC, 8);
    chk("hour_23", 32'({set_hour_shi, set_hour_ge}), 32'h23);
    press(K_INC, 8);
    chk("hour_wrap", 32'({set_hour_shi, set_hour_ge}), 32'h00);
    chk("hour_wrap_min", 32'({set_min_shi, set_min_ge}), 32'h59);

    press(K_SEL, 8);
    press(K_SEL, 8);
    chk("field_sec", 32'(cur_field), 2);
    press(K_INC, 8);
    chk("sec_46", 32'({set_sec_shi, set_sec_ge}), 32'h46);
    repeat (13) press(K_INC, 8);
    chk("sec_59", 32'({set_sec_shi, set_sec_ge}), 32'h59);
    press(K_INC, 8);
    chk("sec_wrap", 32'({set_sec_shi, set_sec_ge}), 32'h00);
    chk("sec_wrap_min", 32'({set_min_shi, set_min_ge}), 32'h59);
    press(K_MODE, 8);
    chk("sa_fin", 32'(set_time_finish), 1);
    chk("sa_mode", 32'(mode), 2);
    chk("sa_field", 32'(cur_field), 0);

    press(K_SEL, 8);
    chk("sa_field_min", 32'(cur_field), 1);
    repeat (59) press(K_INC, 8);
    chk("al_min_59", 32'({clock_min_shi, clock_min_ge}), 32'h59);
    press(K_INC, 8);
    chk("al_min_wrap", 32'({clock_min_shi, clock_min_ge}), 32'h00);
    chk("al_hour_kept", 32'({clock_hour_shi, clock_hour_ge}), 32'h07);
    press(K_SEL, 8);
    chk("sa_field_hour", 32'(cur_field), 0);
    press(K_SEL, 8);
    press(K_SEL, 8);
    chk("sa_never_sec", 32'(cur_field), 0);
    press(K_MODE, 8);
    chk("back_run", 32'(mode), 0);

    press(K_MODE | K_INC, 8);
    chk("simul_mode", 32'(mode), 1);
    chk("simul_en_kept", 32'(clock_en), 1);
    press(K_INC, 8);
    chk("edit_hour_01", 32'({set_hour_shi, set_hour_ge}), 32'h01);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_literals("midreset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Random key activity: bounces, presses and overlapping keys.
    for (int k = 0; k < 3; k++) begin rem[k] = 0; lv[k] = 1'b1; end
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          lv[k]  = 1'($urandom_range(0, 1));
          rem[k] = (k == 0 && !lv[k]) ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 14));
        end
        rem[k]--;
      end
      key_mode_n = lv[0] | ($urandom_range(0, 3) != 0);
      key_sel_n  = lv[1];
      key_inc_n  = lv[2];
      tick();
    end
    set_keys(3'b000);
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
